// File: rtl/clk_div_pkg.sv
// Shared constants, divisor type and high-phase length for the programmable clock divider.
// DUTY50_EN selects floor(N/2) high phase (half-cycle extension added by clk_div_negext).
package clk_div_pkg;
    localparam int DIV_MIN   = 2;
    localparam int DIV_W_DEF = 8;

    typedef logic [DIV_W_DEF-1:0] div_t;

    function automatic int unsigned hi_len(input int unsigned n);
`ifdef DUTY50_EN
        return n / 2;
`else
        return (n + 1) / 2;
`endif
    endfunction
endpackage

// File: rtl/clk_div_prog_if.sv
// Control/status bundle of the programmable clock divider.
interface clk_div_prog_if #(parameter int DIV_W = 8);
    logic             en;
    logic [DIV_W-1:0] div_val;
    logic             div_load;
    logic             clk_out;
    logic             tick;
    logic             div_ack;
    logic             div_err;

    modport master (output en, div_val, div_load, input clk_out, tick, div_ack, div_err);
    modport slave  (input en, div_val, div_load, output clk_out, tick, div_ack, div_err);
endinterface

// File: rtl/clk_div_negext.sv
// Negedge copy of the posedge output; OR-ing it in stretches the high phase by half a clk.
module clk_div_negext (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    always_ff @(negedge clk or posedge rst) begin
        if (rst) q <= 1'b0;
        else     q <= d;
    end
endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with glitch-free divisor updates at period boundaries.
// Optional DUTY50_EN: exact 50% duty for odd divisors via a negedge extender.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic          clk,
    input  logic          rst,
    clk_div_prog_if.slave bus
);
    logic [DIV_W-1:0] cnt, div_act, pend, last_cnt, hi;
    logic pend_vld, pos_q, tick_q, ack_q, err_q;
    logic last, apply, low_req;

    assign last_cnt = div_act - 1'b1;
    assign last     = (cnt == last_cnt);
    assign hi       = DIV_W'(hi_len(32'(div_act)));
    assign apply    = pend_vld && (!bus.en || last);
    assign low_req  = (bus.div_val < DIV_W'(DIV_MIN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            div_act  <= DIV_W'(DEFAULT_DIV);
            pend     <= DIV_W'(DEFAULT_DIV);
            pend_vld <= 1'b0;
            pos_q    <= 1'b0;
            tick_q   <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            if (bus.en) begin
                cnt    <= last ? '0 : cnt + 1'b1;
                pos_q  <= (cnt < hi);
                tick_q <= last;
            end else begin
                cnt    <= '0;
                pos_q  <= 1'b0;
                tick_q <= 1'b0;
            end
            if (apply) begin
                div_act  <= pend;
                cnt      <= '0;
                pend_vld <= 1'b0;
                ack_q    <= 1'b1;
            end
            // A load on the apply edge lands after the apply, so it stays pending.
            if (bus.div_load) begin
                pend     <= low_req ? DIV_W'(DIV_MIN) : bus.div_val;
                pend_vld <= 1'b1;
                if (low_req) err_q <= 1'b1;
            end
        end
    end

`ifdef DUTY50_EN
    logic neg_q;

    clk_div_negext u_negext (
        .clk (clk),
        .rst (rst),
        .d   (pos_q),
        .q   (neg_q)
    );

    assign bus.clk_out = pos_q | (neg_q & div_act[0]);
`else
    assign bus.clk_out = pos_q;
`endif

    assign bus.tick    = tick_q;
    assign bus.div_ack = ack_q;
    assign bus.div_err = err_q;
endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: a cycle model pushes expected {clk_out,tick,div_ack,div_err}.
module tb_clk_div_prog;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vecs = 0;
    int   miss = 0;

    clk_div_prog_if #(.DIV_W(8)) bus ();

    clk_div_prog #(.DIV_W(8), .DEFAULT_DIV(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [3:0] sb[$];
    int   m_cnt, m_act, m_pend;
    logic m_pv, m_err, m_pos;

    function automatic int m_hi(input int n);
`ifdef DUTY50_EN
        return n / 2;
`else
        return (n + 1) / 2;
`endif
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_act = 2; m_pend = 2; m_pv = 1'b0; m_err = 1'b0; m_pos = 1'b0;
        sb.delete();
    endtask

    // Drive one cycle, push the model's expectation, sample #1 after the edge.
    task automatic cycle(input logic e, input logic l, input int v,
                         output logic [3:0] obs, output logic [3:0] exp);
        logic last, pos, tck, ack, clk_exp;
        bus.en = e; bus.div_load = l; bus.div_val = 8'(v);
        last = (m_cnt == m_act - 1);
        pos  = e && (m_cnt < m_hi(m_act));
        tck  = e && last;
        ack  = m_pv && (!e || last);
        m_cnt = e ? (last ? 0 : m_cnt + 1) : 0;
        if (ack) begin m_act = m_pend; m_cnt = 0; m_pv = 1'b0; end
        if (l) begin
            m_pend = (v < 2) ? 2 : v;
            m_pv = 1'b1;
            if (v < 2) m_err = 1'b1;
        end
`ifdef DUTY50_EN
        clk_exp = pos | (m_pos & m_act[0]);
`else
        clk_exp = pos;
`endif
        m_pos = pos;
        sb.push_back({clk_exp, tck, ack, m_err});
        @(posedge clk); #1;
        bus.div_load = 1'b0;
        obs = {bus.clk_out, bus.tick, bus.div_ack, bus.div_err};
        exp = sb.pop_front();
    endtask

    task automatic test_reset();
        logic [3:0] o;
        rst = 1'b1; bus.en = 1'b0; bus.div_load = 1'b0; bus.div_val = '0;
        repeat (2) @(posedge clk);
        #1;
        o = {bus.clk_out, bus.tick, bus.div_ack, bus.div_err};
        vecs++;
        if (o !== 4'b0000) begin miss++; $display("FAIL reset_outputs got %b exp 0000", o); end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_default_div();
        logic [3:0] o, x;
        int ticks = 0, highs = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 0, o, x);
            vecs++;
            if (o !== x) begin miss++; $display("FAIL default_div cyc %0d got %b exp %b", i, o, x); end
            ticks += int'(o[2]); highs += int'(o[3]);
        end
        vecs++;
        if (ticks != 4 || highs != 4) begin
            miss++; $display("FAIL default_div_counts got ticks %0d highs %0d exp 4 4", ticks, highs);
        end
    endtask

    task automatic test_load_div(input int n, input int exp_hi);
        logic [3:0] o, x;
        int acks = 0, ticks = 0, highs = 0;
        bit got = 0;
        cycle(1'b1, 1'b1, n, o, x);
        vecs++;
        if (o !== x) begin miss++; $display("FAIL load%0d_req got %b exp %b", n, o, x); end
        for (int i = 0; i < 20 && !got; i++) begin
            cycle(1'b1, 1'b0, 0, o, x);
            vecs++;
            if (o !== x) begin miss++; $display("FAIL load%0d_wait cyc %0d got %b exp %b", n, i, o, x); end
            if (o[1]) begin got = 1; acks++; end
        end
        vecs++;
        if (!got) begin miss++; $display("FAIL load%0d_ack got timeout exp ack", n); end
        for (int i = 0; i < 2 * n; i++) begin
            cycle(1'b1, 1'b0, 0, o, x);
            vecs++;
            if (o !== x) begin miss++; $display("FAIL load%0d_run cyc %0d got %b exp %b", n, i, o, x); end
            acks += int'(o[1]); ticks += int'(o[2]); highs += int'(o[3]);
        end
        vecs++;
        if (acks != 1 || ticks != 2 || highs != 2 * exp_hi) begin
            miss++;
            $display("FAIL load%0d_counts got acks %0d ticks %0d highs %0d exp 1 2 %0d",
                     n, acks, ticks, highs, 2 * exp_hi);
        end
    endtask

    task automatic test_enable();
        logic [3:0] o, x;
        cycle(1'b0, 1'b1, 3, o, x);
        vecs++;
        if (o !== x) begin miss++; $display("FAIL en_off_load got %b exp %b", o, x); end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 0, o, x);
            vecs++;
            if (o !== x) begin miss++; $display("FAIL en_off cyc %0d got %b exp %b", i, o, x); end
        end
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0, 0, o, x);
            vecs++;
            if (o !== x) begin miss++; $display("FAIL en_on cyc %0d got %b exp %b", i, o, x); end
        end
    endtask

    task automatic test_mid_period_load();
        logic [3:0] o, x;
        int idx = 0, last_t = -1, k = 0;
        int gaps[2];
        bit got = 0;
        gaps[0] = 0; gaps[1] = 0;
        cycle(1'b1, 1'b1, 8, o, x);
        for (int i = 0; i < 20 && !got; i++) begin
            cycle(1'b1, 1'b0, 0, o, x);
            vecs++;
            if (o !== x) begin miss++; $display("FAIL mid_wait cyc %0d got %b exp %b", i, o, x); end
            if (o[1]) got = 1;
        end
        for (int i = 0; i < 10 && m_cnt != 2; i++) begin
            cycle(1'b1, 1'b0, 0, o, x);
            idx++;
            vecs++;
            if (o !== x) begin miss++; $display("FAIL mid_align cyc %0d got %b exp %b", i, o, x); end
        end
        cycle(1'b1, 1'b1, 3, o, x);
        idx++;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, 0, o, x);
            idx++;
            vecs++;
            if (o !== x) begin miss++; $display("FAIL mid_run cyc %0d got %b exp %b", i, o, x); end
            if (o[2]) begin
                if (k < 2) gaps[k] = idx - last_t;
                k++;
                last_t = idx;
            end
        end
        vecs++;
        if (gaps[1] != 3 || last_t < 0) begin
            miss++; $display("FAIL mid_period_gap got %0d exp 3", gaps[1]);
        end
        vecs++;
        if (k < 3) begin miss++; $display("FAIL mid_period_ticks got %0d exp >=3", k); end
    endtask

    task automatic test_err();
        logic [3:0] o, x;
        int v;
        for (int j = 0; j < 2; j++) begin
            v = 1 - j;
            cycle(1'b1, 1'b1, v, o, x);
            vecs++;
            if (o !== x) begin miss++; $display("FAIL err_load%0d got %b exp %b", v, o, x); end
            vecs++;
            if (o[0] !== 1'b1) begin miss++; $display("FAIL err_sticky got %b exp 1", o[0]); end
            for (int i = 0; i < 10; i++) begin
                cycle(1'b1, 1'b0, 0, o, x);
                vecs++;
                if (o !== x) begin miss++; $display("FAIL err_run%0d cyc %0d got %b exp %b", v, i, o, x); end
            end
        end
    endtask

    task automatic test_reset_mid_period();
        logic [3:0] o, x;
        int acks = 0, ticks = 0;
        bit got = 0;
        cycle(1'b1, 1'b1, 6, o, x);
        for (int i = 0; i < 20 && !got; i++) begin
            cycle(1'b1, 1'b0, 0, o, x);
            vecs++;
            if (o !== x) begin miss++; $display("FAIL rstmid_wait cyc %0d got %b exp %b", i, o, x); end
            if (o[1]) got = 1;
        end
        for (int i = 0; i < 10 && m_cnt != 1; i++) cycle(1'b1, 1'b0, 0, o, x);
        cycle(1'b1, 1'b1, 4, o, x);
        cycle(1'b1, 1'b0, 0, o, x);
        vecs++;
        if (o !== x || o[3] !== 1'b1) begin miss++; $display("FAIL rstmid_pre got %b exp %b", o, x); end
        #2 rst = 1'b1;
        #1;
        o = {bus.clk_out, bus.tick, bus.div_ack, bus.div_err};
        vecs++;
        if (o !== 4'b0000) begin miss++; $display("FAIL rstmid_async got %b exp 0000", o); end
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 0, o, x);
            vecs++;
            if (o !== x) begin miss++; $display("FAIL rstmid_run cyc %0d got %b exp %b", i, o, x); end
            acks += int'(o[1]); ticks += int'(o[2]);
        end
        vecs++;
        if (acks != 0 || ticks != 4) begin
            miss++; $display("FAIL rstmid_counts got acks %0d ticks %0d exp 0 4", acks, ticks);
        end
    endtask

    initial begin
        test_reset();
        test_default_div();
        test_load_div(4, 2);
        test_load_div(5, 3);
        test_enable();
        test_mid_period_load();
        test_err();
        test_reset_mid_period();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
